// File: rtl/alnpc_retire_reader.sv
// Commit-side reader of the active-list next-PC RAM.
// Owns the RAM read port (address = head pointer), advances the head on each
// retirement, captures the next-PC for redirecting retirements, and holds
// commit stalled until the pipeline flush that follows a redirect.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_READY | next-PC RAM not ready; commit stalled, head held
// RUN        | normal retirement; head advances on each accepted commit
// DRAIN      | redirect issued; commit stalled until flush restarts the list

module alnpc_retire_reader #(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ramReady_i,
    input  logic             commitValid_i,
    input  logic             needNpc_i,
    input  logic             flush_i,
    output logic [INDEX-1:0] addr0_o,
    input  logic [WIDTH-1:0] data0_i,
    output logic             stallCommit_o,
    output logic             redirectValid_o,
    output logic [WIDTH-1:0] redirectPc_o,
    output logic [31:0]      retireCount_o
);

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2
    } state_t;

    // Last valid active-list index; the head wraps here so non-power-of-2
    // depths never address past the end of the list.
    localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [INDEX-1:0]  head_ptr;
    logic [INDEX-1:0]  head_nxt;
    logic [INDEX-1:0]  head_inc;
    logic [WIDTH-1:0]  redirect_pc;
    logic              redirect_valid;
    logic              redirect_set;
    logic [31:0]       retire_cnt;
    logic              retire;
    logic              count_en;
    logic              stall;

    // Wrapped increment of the head pointer.
    always_comb begin
        head_inc = '0;
        if (head_ptr != LAST_IDX) begin
            head_inc = head_ptr + INDEX'(1);
        end
    end

    // Next-state, head update, redirect capture and count enable.
    always_comb begin
        state_nxt    = state;
        head_nxt     = head_ptr;
        redirect_set = 1'b0;
        count_en     = 1'b0;
        stall        = 1'b1;
        retire       = 1'b0;

        case (state)
            WAIT_READY: begin
                stall = 1'b1;
                if (flush_i) begin
                    head_nxt = '0;
                end
                if (ramReady_i) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                stall  = 1'b0;
                retire = commitValid_i;
                if (flush_i) begin
                    // Flush wins; a same-cycle commit is dropped and uncounted.
                    head_nxt = '0;
                end else if (!ramReady_i) begin
                    state_nxt = WAIT_READY;
                end else if (retire) begin
                    head_nxt = head_inc;
                    count_en = 1'b1;
                    if (needNpc_i) begin
                        redirect_set = 1'b1;
                        state_nxt    = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // RAM readiness is only reconsidered once the flush arrives.
                stall = 1'b1;
                if (flush_i) begin
                    head_nxt  = '0;
                    state_nxt = ramReady_i ? RUN : WAIT_READY;
                end
            end

            default: begin
                state_nxt = WAIT_READY;
                head_nxt  = '0;
            end
        endcase
    end

    // State and head pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_READY;
            head_ptr <= '0;
        end else begin
            state    <= state_nxt;
            head_ptr <= head_nxt;
        end
    end

    // Redirect capture: PC is read at the pre-advance head, valid pulses once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_pc    <= '0;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= redirect_set;
            if (redirect_set) begin
                redirect_pc <= data0_i;
            end
        end
    end

    // Saturating retirement counter; flush does not clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (count_en && (retire_cnt != 32'hFFFF_FFFF)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign addr0_o         = head_ptr;
    assign stallCommit_o   = stall;
    assign redirectValid_o = redirect_valid;
    assign redirectPc_o    = redirect_pc;
    assign retireCount_o   = retire_cnt;

endmodule
